// File: rtl/pipeline_regs.sv
// pipeline_regs
// In-order pipeline register chain carrying a WIDTH-bit payload and a valid
// bit through STAGES registers (stage 0 = FD ... stage STAGES-1 = MW).
// Supports hold-and-bubble stalls, front-end flush on a resolved branch, and
// a built-in periodic stall generator. Flush outranks stall, stall outranks
// normal advance.

module pipeline_regs #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int HOLD_STAGES  = 1,
    parameter int FLUSH_STAGES = 2,
    parameter int STALL_PERIOD = 5,
    localparam int CNT_W       = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      stall_req,
    input  logic                      flush,
    input  logic                      auto_stall_en,
    output logic                      fetch_stall,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CNT_W-1:0]          auto_count
);

    // Parameter sanity: a misconfigured chain is caught at elaboration.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("pipeline_regs: WIDTH must be >= 1");
        end
        if (STAGES < 2) begin : g_bad_stages
            $error("pipeline_regs: STAGES must be >= 2");
        end
        if ((HOLD_STAGES < 1) || (HOLD_STAGES > STAGES - 1)) begin : g_bad_hold
            $error("pipeline_regs: HOLD_STAGES must be in 1..STAGES-1");
        end
        if ((FLUSH_STAGES < 1) || (FLUSH_STAGES > STAGES)) begin : g_bad_flush
            $error("pipeline_regs: FLUSH_STAGES must be in 1..STAGES");
        end
        if (STALL_PERIOD < 2) begin : g_bad_period
            $error("pipeline_regs: STALL_PERIOD must be >= 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);

    logic [CNT_W-1:0]             count_q;
    logic                         auto_stall;
    logic                         stall;
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0][WIDTH-1:0] data_d;

    // Periodic stall counter: runs 0..STALL_PERIOD-1 while enabled, parks at 0 otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (!auto_stall_en) begin
            count_q <= '0;
        end else if (count_q == CNT_LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    // Stall sources combine by OR; fetch is never held on a flush or during reset.
    always_comb begin
        auto_stall  = auto_stall_en & (count_q != '0);
        stall       = stall_req | auto_stall;
        fetch_stall = stall & ~flush & ~reset;
    end

    // Next-state of every stage: flush beats stall, stall beats advance.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d[0] = 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                if (k < FLUSH_STAGES) begin
                    valid_d[k] = 1'b0;
                end else begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end else if (stall) begin
            for (int k = 1; k < STAGES; k++) begin
                if (k == HOLD_STAGES) begin
                    valid_d[k] = 1'b0;
                end else if (k > HOLD_STAGES) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end else begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // Stage registers; reset clears both valid and payload so nothing stale leaks out.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Expose the stage registers and the writeback end of the chain.
    always_comb begin
        stage_valid = valid_q;
        stage_data  = data_q;
        out_valid   = valid_q[STAGES-1];
        out_data    = data_q[STAGES-1];
        auto_count  = count_q;
    end

endmodule
